// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - requester/arbiter bundle for the shared 4:1 mux
interface mux_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       sel_valid;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  grant,
        input  sel,
        input  sel_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output sel,
        output sel_valid,
        output timeout
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin owner arbiter driving a 4:1 mux select
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_rr_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic             sel_valid_q, sel_valid_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [1:0] winner;
    logic [1:0] scan_idx;
    logic       found;
    logic       any_req;
    logic       owner_done;
    logic       owner_req;
    logic       at_limit;

    assign any_req    = |bus.req;
    assign owner_done = bus.done[sel_q];
    assign owner_req  = bus.req[sel_q];
    assign at_limit   = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

    // Scan last+1 .. last+4 so the previous owner is considered last.
    always_comb begin
        winner   = last_q;
        scan_idx = last_q;
        found    = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            scan_idx = last_q + 2'(i);
            if (!found && bus.req[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        last_d      = last_q;
        sel_valid_d = sel_valid_q;
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                if (any_req) begin
                    state_d     = OWN;
                    grant_d     = 4'(1) << winner;
                    sel_d       = winner;
                    sel_valid_d = 1'b1;
                    last_d      = winner;
                    hold_cnt_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
                if (owner_done || !owner_req || at_limit) begin
                    state_d     = GAP;
                    grant_d     = 4'b0000;
                    sel_valid_d = 1'b0;
                    // Only a still-requesting owner without done was cut off by the limit.
                    timeout_d   = owner_req && !owner_done;
                end
            end
            default: begin
                state_d     = IDLE;
                grant_d     = 4'b0000;
                sel_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= 4'b0000;
            sel_q       <= 2'b00;
            last_q      <= 2'd3;
            sel_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            sel_valid_q <= sel_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    mux_rr_arbiter_if bus ();

    mux_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        bus.req  = 4'b0000;
        bus.done = 4'b0000;
        rst_n    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        bus.req  = 4'b1111;
        bus.done = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        tests++; if (bus.grant !== 4'b0000) begin fails++; $display("FAIL reset_grant got=%b exp=0000", bus.grant); end
        tests++; if (bus.sel !== 2'b00) begin fails++; $display("FAIL reset_sel got=%b exp=00", bus.sel); end
        tests++; if (bus.sel_valid !== 1'b0) begin fails++; $display("FAIL reset_sel_valid got=%b exp=0", bus.sel_valid); end
        tests++; if (bus.timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout got=%b exp=0", bus.timeout); end
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (bus.grant !== 4'b0001) begin fails++; $display("FAIL reset_first_grant got=%b exp=0001", bus.grant); end
        tests++; if (bus.sel_valid !== 1'b1) begin fails++; $display("FAIL reset_first_valid got=%b exp=1", bus.sel_valid); end
    endtask

    task automatic test_single();
        logic [3:0] eg [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        do_reset();
        bus.req = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++; if (bus.grant !== eg[i]) begin fails++; $display("FAIL single_grant cyc=%0d got=%b exp=%b", i, bus.grant, eg[i]); end
            tests++; if (bus.sel !== 2'b10) begin fails++; $display("FAIL single_sel cyc=%0d got=%b exp=10", i, bus.sel); end
            tests++; if (bus.sel_valid !== (eg[i] != 4'b0000)) begin fails++; $display("FAIL single_valid cyc=%0d got=%b", i, bus.sel_valid); end
            tests++; if (bus.timeout !== 1'b0) begin fails++; $display("FAIL single_timeout cyc=%0d got=%b exp=0", i, bus.timeout); end
            if (i == 2) begin
                bus.done = 4'b0100;
                bus.req  = 4'b0000;
            end else begin
                bus.done = 4'b0000;
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg [13] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                                4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
        logic [1:0] es [13] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                                2'd3, 2'd3, 2'd3, 2'd0};
        logic [3:0] dd [13] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000,
                                4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
        do_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            tests++; if (bus.grant !== eg[i]) begin fails++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", i, bus.grant, eg[i]); end
            tests++; if (bus.sel !== es[i]) begin fails++; $display("FAIL rr_sel cyc=%0d got=%0d exp=%0d", i, bus.sel, es[i]); end
            tests++; if (bus.sel_valid !== (eg[i] != 4'b0000)) begin fails++; $display("FAIL rr_valid cyc=%0d got=%b", i, bus.sel_valid); end
            bus.done = dd[i];
        end
    endtask

    task automatic test_timeout();
        logic [3:0] exp_g;
        logic       exp_t;
        logic [1:0] exp_s;
        do_reset();
        bus.req = 4'b0011;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            exp_g = (i <= 8) ? 4'b0001 : ((i == 9) ? 4'b0000 : 4'b0010);
            exp_t = (i == 9);
            exp_s = (i == 10) ? 2'd1 : 2'd0;
            tests++; if (bus.grant !== exp_g) begin fails++; $display("FAIL to_grant cyc=%0d got=%b exp=%b", i, bus.grant, exp_g); end
            tests++; if (bus.timeout !== exp_t) begin fails++; $display("FAIL to_pulse cyc=%0d got=%b exp=%b", i, bus.timeout, exp_t); end
            tests++; if (bus.sel !== exp_s) begin fails++; $display("FAIL to_sel cyc=%0d got=%0d exp=%0d", i, bus.sel, exp_s); end
        end
    endtask

    task automatic test_sole_hog();
        logic [3:0] exp_g;
        logic       exp_t;
        do_reset();
        bus.req = 4'b1000;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            exp_t = ((i - 1) % 9) == 8;
            exp_g = exp_t ? 4'b0000 : 4'b1000;
            tests++; if (bus.grant !== exp_g) begin fails++; $display("FAIL hog_grant cyc=%0d got=%b exp=%b", i, bus.grant, exp_g); end
            tests++; if (bus.timeout !== exp_t) begin fails++; $display("FAIL hog_pulse cyc=%0d got=%b exp=%b", i, bus.timeout, exp_t); end
            tests++; if (bus.sel !== 2'b11) begin fails++; $display("FAIL hog_sel cyc=%0d got=%b exp=11", i, bus.sel); end
        end
    endtask

    task automatic test_done_at_limit();
        logic [3:0] exp_g;
        do_reset();
        bus.req = 4'b0001;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            exp_g = (i == 9) ? 4'b0000 : 4'b0001;
            tests++; if (bus.grant !== exp_g) begin fails++; $display("FAIL lim_grant cyc=%0d got=%b exp=%b", i, bus.grant, exp_g); end
            tests++; if (bus.timeout !== 1'b0) begin fails++; $display("FAIL lim_pulse cyc=%0d got=%b exp=0", i, bus.timeout); end
            case (i)
                3:       bus.done = 4'b1110;
                8:       bus.done = 4'b0001;
                9:       bus.done = 4'b1111;
                default: bus.done = 4'b0000;
            endcase
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req = 4'b0010;
        @(negedge clk);
        tests++; if (bus.grant !== 4'b0010) begin fails++; $display("FAIL ar_pre_grant got=%b exp=0010", bus.grant); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (bus.grant !== 4'b0000) begin fails++; $display("FAIL ar_grant got=%b exp=0000", bus.grant); end
        tests++; if (bus.sel_valid !== 1'b0) begin fails++; $display("FAIL ar_valid got=%b exp=0", bus.sel_valid); end
        tests++; if (bus.sel !== 2'b00) begin fails++; $display("FAIL ar_sel got=%b exp=00", bus.sel); end
        @(negedge clk);
        bus.req = 4'b0110;
        rst_n   = 1'b1;
        @(negedge clk);
        tests++; if (bus.grant !== 4'b0010) begin fails++; $display("FAIL ar_regrant got=%b exp=0010", bus.grant); end
        tests++; if (bus.sel !== 2'b01) begin fails++; $display("FAIL ar_resel got=%b exp=01", bus.sel); end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_sole_hog();
        test_done_at_limit();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
